sfp_norm: RTL and testbench
===========================

# sfp_norm

Special-function stage downstream of the PSUM memory and output FIFO. It accepts one row of `col` signed partial sums and accumulates the sum of their absolute values. It then normalizes each element to a signed fixed-point ratio of that sum with a serial divider. The normalized row and the absolute sum are presented on a valid/ready output, which drives the core's `sfp_out` bus and `sum_out` port.

## Interface

Parameters:
- `col`, 8, number of elements per row.
- `bw_psum`, 20, width of each signed input element and each signed output element.
- `frac`, 8, number of fractional bits in the normalized output.
- `sum_bw`, `bw_psum+8`, width of the absolute-sum accumulator and of `sum_out`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: `in_data` holds a valid row.
- `in_ready`, out, 1: block can accept a row.
- `in_data`, in, `col*bw_psum`: input row. Element i is `in_data[(i+1)*bw_psum-1 : i*bw_psum]`, two's complement.
- `out_valid`, out, 1: `out` and `sum_out` are valid.
- `out_ready`, in, 1: consumer accepts the result.
- `out`, out, `col*bw_psum`: normalized row, packed the same way as `in_data`, two's complement.
- `sum_out`, out, `sum_bw`: unsigned sum of |element| over the row.

## Operation

- States: `IDLE`, `SUM`, `DIV`, `DONE`.
- `IDLE`:
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture `in_data` into the row register, clear the accumulator, set element index 0, go to `SUM`.
- `SUM`:
  - One element per cycle: `acc += |x_i|`, where |x| is computed as an unsigned `bw_psum`-bit value. |−2^(bw_psum−1)| = 2^(bw_psum−1) is exact, with no overflow.
  - After element col−1: if the final acc is 0, set all outputs to 0 and go to `DONE`; otherwise go to `DIV` with index 0.
- `DIV`:
  - For each element, run an unsigned restoring divide of dividend `|x_i| << frac` (width DW=`bw_psum+frac`) by divisor `acc`. The divider produces one quotient bit per cycle, DW cycles per element.
  - The quotient is ≤ 2^frac, so it always fits in `bw_psum` bits and no saturation is needed.
  - out_i = quotient if x_i ≥ 0, else −quotient (two's complement). Truncation is toward zero.
  - After element col−1 completes, go to `DONE`.
- `DONE`:
  - `out_valid`=1; `out` and `sum_out` are held stable.
  - On `out_ready`, go to `IDLE`. A new row cannot be accepted on that same edge.
- `in_valid` is ignored outside `IDLE`. `in_data` only needs to be stable on the accepting edge.
- `sum_out` = acc, zero-extended. Maximum value col·2^(bw_psum−1) < 2^sum_bw.

## Timing

- Reset values: state `IDLE`, `in_ready`=1, `out_valid`=0, `out`=0, `sum_out`=0; accumulator, index and divider registers all cleared.
- Reset asserted mid-operation aborts immediately and discards the row. After reset deasserts, the block is in `IDLE` with no output.
- Label the accepting edge E0.
- Latency, nonzero sum:
  - `SUM` occupies edges E1..E_col.
  - `DIV` occupies col·DW edges.
  - `out_valid` rises after edge E(col + col·DW). With defaults this is E232.
- Latency, zero sum: `out_valid` rises after edge E_col (E8).
- Throughput: one row per col + col·DW + 2 cycles at best. `in_ready` is low from E0 until the edge after the `out_ready` handshake.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Package `sfp_pkg` holds:
  - the state enum `{IDLE, SUM, DIV, DONE}`;
  - the default `FRAC`=8;
  - the `abs` function used by both the top level and the bench model.
- Sub-module `sfp_div_serial`: a parameterized (DW, divisor width) restoring divider with `start`/`done`, one quotient bit per cycle, the same `clk`/`reset`, and its own bit counter.
- The top level owns the FSM, the row register, the accumulator, the element index and sign restoration.

## Test plan

- All eight elements = 1 -> `sum_out`=8; every out_i=32; `out_valid` after edge E232.
- x0=−4, x1..x7=4 -> `sum_out`=32; out0=−32 (0xFFFE0); others 32.
- All-zero row -> `sum_out`=0; all out_i=0; `out_valid` after edge E8.
- x0=−524288, others 0 -> `sum_out`=524288; out0=−256; others 0.
- `out_ready` held low 10 cycles in `DONE` while `in_valid`=1 with a new row -> `out`/`sum_out` stable and `in_ready`=0 throughout. After `out_ready`=1, `in_ready` rises on the next cycle, and the second row produces the correct result.
- `reset` pulsed mid-`DIV` on row 1 -> outputs 0 and `IDLE` immediately. The next row (all 2s) gives `sum_out`=16 and out_i=32, with no residue from row 1.

Source files
------------

// File: rtl/sfp_pkg.sv
// Shared types, defaults and helpers for the sfp_norm special-function stage.
package sfp_pkg;

  typedef enum logic [1:0] {IDLE, SUM, DIV, DONE} state_t;

  localparam int FRAC = 8;

  // Magnitude of a sign-extended value; callers truncate to their element width.
  function automatic logic [63:0] abs(input logic signed [63:0] v);
    return v[63] ? -v : v;
  endfunction

endpackage

// File: rtl/sfp_norm_if.sv
// Row-in / result-out handshake bundle for sfp_norm; master is upstream/consumer, slave is the block.
interface sfp_norm_if #(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int sum_bw  = bw_psum + 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [col*bw_psum-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [col*bw_psum-1:0]   out;
  logic [sum_bw-1:0]        sum_out;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out, sum_out
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out, sum_out
  );
endinterface

// File: rtl/sfp_div_serial.sv
// Unsigned restoring divider, one quotient bit per cycle; the start cycle already produces the first bit,
// and done/quotient are combinational on the final step so the caller can capture without an extra cycle.
module sfp_div_serial #(
  parameter int DW = 28,
  parameter int VW = 28
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient
);
  localparam int CW = $clog2(DW) + 1;

  logic [VW-1:0] rem;
  logic [DW-1:0] q;
  logic [CW-1:0] cnt;

  logic [VW-1:0] rem_cur;
  logic [DW-1:0] q_cur;
  logic [CW-1:0] cnt_cur;
  logic [VW:0]   rem_shift;
  logic [VW-1:0] rem_nxt;
  logic          ge;
  logic          step;

  always_comb begin
    step      = start || busy;
    rem_cur   = start ? '0 : rem;
    q_cur     = start ? dividend : q;
    cnt_cur   = start ? '0 : cnt;
    rem_shift = {rem_cur, q_cur[DW-1]};
    ge        = (rem_shift >= {1'b0, divisor});
    rem_nxt   = ge ? VW'(rem_shift - {1'b0, divisor}) : rem_shift[VW-1:0];
    quotient  = {q_cur[DW-2:0], ge};
    done      = step && (cnt_cur == CW'(DW - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem  <= '0;
      q    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (step) begin
      rem  <= rem_nxt;
      q    <= quotient;
      cnt  <= cnt_cur + 1'b1;
      busy <= !done;
    end
  end

endmodule

// File: rtl/sfp_norm.sv
// Row normalizer: sums |x_i| over a row, then divides each |x_i|<<frac by that sum and restores the sign.
module sfp_norm
  import sfp_pkg::*;
#(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int frac    = FRAC,
  parameter int sum_bw  = bw_psum + 8
) (
  input logic       clk,
  input logic       reset,
  sfp_norm_if.slave bus
);
  localparam int DW = bw_psum + frac;
  localparam int IW = $clog2(col);

  state_t state, state_nxt;

  logic [col*bw_psum-1:0] row;
  logic [col*bw_psum-1:0] out_reg;
  logic [sum_bw-1:0]      acc;
  logic [sum_bw-1:0]      acc_nxt;
  logic [IW-1:0]          idx;

  logic [bw_psum-1:0]     x;
  logic [bw_psum-1:0]     ax;
  logic [bw_psum-1:0]     q_mag;
  logic [bw_psum-1:0]     res;
  logic                   neg;
  logic                   last_elem;
  logic                   div_start;
  logic                   div_busy;
  logic                   div_done;
  logic [DW-1:0]          div_q;

  // The quotient never exceeds 2^frac, so truncating it to the element width is lossless.
  always_comb begin
    x         = row[idx*bw_psum +: bw_psum];
    neg       = x[bw_psum-1];
    ax        = bw_psum'(abs(64'(signed'(x))));
    acc_nxt   = acc + sum_bw'(ax);
    last_elem = (idx == IW'(col - 1));
    q_mag     = bw_psum'(div_q);
    res       = neg ? -q_mag : q_mag;
    div_start = (state == DIV) && !div_busy;
  end

  sfp_div_serial #(
    .DW(DW),
    .VW(sum_bw)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend ({ax, {frac{1'b0}}}),
    .divisor  (acc),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = SUM;
      SUM:     if (last_elem) state_nxt = (acc_nxt == '0) ? DONE : DIV;
      DIV:     if (div_done && last_elem) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row     <= '0;
      out_reg <= '0;
      acc     <= '0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            row     <= bus.in_data;
            out_reg <= '0;
            acc     <= '0;
            idx     <= '0;
          end
        end
        SUM: begin
          acc <= acc_nxt;
          idx <= last_elem ? '0 : idx + 1'b1;
          if (last_elem && (acc_nxt == '0)) out_reg <= '0;
        end
        DIV: begin
          if (div_done) begin
            out_reg[idx*bw_psum +: bw_psum] <= res;
            idx <= last_elem ? '0 : idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_reg;
  assign bus.sum_out   = acc;

endmodule

// File: tb/tb_sfp_norm.sv
// Self-checking bench for sfp_norm: directed test-plan rows, random rows, backpressure and mid-divide reset.
module tb_sfp_norm;
  import sfp_pkg::*;

  localparam int COL  = 8;
  localparam int BW   = 20;
  localparam int FR   = 8;
  localparam int SBW  = BW + 8;
  localparam int W    = COL * BW;
  localparam int LAT  = COL + COL * (BW + FR);
  localparam int LAT0 = COL;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  sfp_norm_if #(.col(COL), .bw_psum(BW), .sum_bw(SBW)) bus ();

  sfp_norm #(.col(COL), .bw_psum(BW), .frac(FR), .sum_bw(SBW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sum of magnitudes, then trunc-toward-zero of x*2^FR/sum in plain integer math.
  function automatic void model(input logic [W-1:0] r, output logic [SBW-1:0] s, output logic [W-1:0] o);
    longint total, a, mag;
    logic [BW-1:0] x;
    total = 0;
    for (int i = 0; i < COL; i++) begin
      x = r[i*BW +: BW];
      total += longint'(abs(64'(signed'(x))));
    end
    s = SBW'(total);
    o = '0;
    for (int i = 0; i < COL; i++) begin
      x   = r[i*BW +: BW];
      a   = longint'(abs(64'(signed'(x))));
      mag = (total == 0) ? 0 : (a * (longint'(1) << FR)) / total;
      o[i*BW +: BW] = BW'(x[BW-1] ? -mag : mag);
    end
  endfunction

  function automatic logic [W-1:0] random_row(input int mode);
    logic [W-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      case (mode)
        0:       v = int'($urandom);
        1:       v = int'($urandom_range(0, 64)) - 32;
        2:       v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2000)) - 1000 : 0;
        3: begin
          case ($urandom_range(0, 4))
            0:       v = -524288;
            1:       v = 524287;
            2:       v = 1;
            3:       v = -1;
            default: v = 0;
          endcase
        end
        default: v = 0;
      endcase
      r[i*BW +: BW] = BW'(v);
    end
    return r;
  endfunction

  task automatic send_row(input logic [W-1:0] r);
    @(negedge clk);
    bus.in_data  = r;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n, output bit seen);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 2 * LAT) begin
      @(posedge clk);
      n++;
      #1;
      seen = bus.out_valid;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.out !== '0) begin
      n_fail++; $display("[TB] FAIL reset_out: got %h expected 0", bus.out);
    end
    n_cmp++;
    if (bus.sum_out !== '0) begin
      n_fail++; $display("[TB] FAIL reset_sum: got %h expected 0", bus.sum_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    int             vals[4][COL] = '{'{1, 1, 1, 1, 1, 1, 1, 1},
                                     '{-4, 4, 4, 4, 4, 4, 4, 4},
                                     '{0, 0, 0, 0, 0, 0, 0, 0},
                                     '{-524288, 0, 0, 0, 0, 0, 0, 0}};
    logic [SBW-1:0] plan_sum[4]  = '{28'd8, 28'd32, 28'd0, 28'd524288};
    int             plan_out0[4] = '{32, -32, 0, -256};
    int             plan_lat[4]  = '{LAT, LAT, LAT0, LAT};
    logic [W-1:0]   r, exp_o;
    logic [SBW-1:0] exp_s;
    int             n;
    bit             seen;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(vals[t][i]);
      model(r, exp_s, exp_o);
      send_row(r);
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++; $display("[TB] FAIL dir%0d_busy: in_ready got %b expected 0", t, bus.in_ready);
      end
      wait_out(n, seen);
      n_cmp++;
      if (!seen || n != plan_lat[t]) begin
        n_fail++; $display("[TB] FAIL dir%0d_latency: got %0d (seen=%0b) expected %0d", t, n, seen, plan_lat[t]);
      end
      n_cmp++;
      if (bus.sum_out !== plan_sum[t]) begin
        n_fail++; $display("[TB] FAIL dir%0d_sum: got %0d expected %0d", t, bus.sum_out, plan_sum[t]);
      end
      n_cmp++;
      if (bus.out[BW-1:0] !== BW'(plan_out0[t])) begin
        n_fail++; $display("[TB] FAIL dir%0d_out0: got %h expected %h", t, bus.out[BW-1:0], BW'(plan_out0[t]));
      end
      n_cmp++;
      if (bus.out !== exp_o) begin
        n_fail++; $display("[TB] FAIL dir%0d_row: got %h expected %h", t, bus.out, exp_o);
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [W-1:0]   r, exp_o;
    logic [SBW-1:0] exp_s;
    int             n;
    bit             seen;
    for (int t = 0; t < 16; t++) begin
      r = (t % 7 == 6) ? '0 : random_row(t % 4);
      model(r, exp_s, exp_o);
      send_row(r);
      wait_out(n, seen);
      n_cmp++;
      if (!seen || n != ((exp_s == '0) ? LAT0 : LAT)) begin
        n_fail++; $display("[TB] FAIL rnd%0d_latency: got %0d (seen=%0b) expected %0d", t, n, seen, (exp_s == '0) ? LAT0 : LAT);
      end
      n_cmp++;
      if (bus.sum_out !== exp_s) begin
        n_fail++; $display("[TB] FAIL rnd%0d_sum: got %0d expected %0d", t, bus.sum_out, exp_s);
      end
      n_cmp++;
      if (bus.out !== exp_o) begin
        n_fail++; $display("[TB] FAIL rnd%0d_row: got %h expected %h", t, bus.out, exp_o);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   ra, rb, exp_a, exp_b;
    logic [SBW-1:0] sum_a, sum_b;
    int             n;
    bit             seen;
    ra = random_row(1);
    ra[BW-1:0] = BW'(5);
    rb = random_row(0);
    rb[BW-1:0] = BW'(-77);
    model(ra, sum_a, exp_a);
    model(rb, sum_b, exp_b);
    send_row(ra);
    wait_out(n, seen);
    n_cmp++;
    if (!seen) begin
      n_fail++; $display("[TB] FAIL b2b_first_valid: got %0b expected 1", seen);
    end
    @(negedge clk);
    bus.in_data   = rb;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out !== exp_a || bus.sum_out !== sum_a || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL b2b_hold%0d: out=%h sum=%0d rdy=%b vld=%b expected out=%h sum=%0d rdy=0 vld=1",
                 c, bus.out, bus.sum_out, bus.in_ready, bus.out_valid, exp_a, sum_a);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_release: rdy=%b vld=%b expected rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_accept: in_ready got %b expected 0", bus.in_ready);
    end
    wait_out(n, seen);
    n_cmp++;
    if (!seen || n != LAT) begin
      n_fail++; $display("[TB] FAIL b2b_latency: got %0d (seen=%0b) expected %0d", n, seen, LAT);
    end
    n_cmp++;
    if (bus.out !== exp_b || bus.sum_out !== sum_b) begin
      n_fail++; $display("[TB] FAIL b2b_second: out=%h sum=%0d expected out=%h sum=%0d", bus.out, bus.sum_out, exp_b, sum_b);
    end
    release_out();
  endtask

  task automatic test_reset_mid_div();
    logic [W-1:0]   r, exp_o;
    int             n;
    bit             seen;
    r = random_row(0);
    r[BW-1:0] = BW'(1234);
    send_row(r);
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL rst_div_ctrl: vld=%b rdy=%b expected vld=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    n_cmp++;
    if (bus.sum_out !== '0 || bus.out !== '0) begin
      n_fail++; $display("[TB] FAIL rst_div_data: sum=%0d out=%h expected 0", bus.sum_out, bus.out);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < COL; i++) begin
      r[i*BW +: BW]     = BW'(2);
      exp_o[i*BW +: BW] = BW'(32);
    end
    send_row(r);
    wait_out(n, seen);
    n_cmp++;
    if (!seen || n != LAT) begin
      n_fail++; $display("[TB] FAIL rst_next_latency: got %0d (seen=%0b) expected %0d", n, seen, LAT);
    end
    n_cmp++;
    if (bus.sum_out !== SBW'(16)) begin
      n_fail++; $display("[TB] FAIL rst_next_sum: got %0d expected 16", bus.sum_out);
    end
    n_cmp++;
    if (bus.out !== exp_o) begin
      n_fail++; $display("[TB] FAIL rst_next_row: got %h expected %h", bus.out, exp_o);
    end
    release_out();
  endtask

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
